// File: rtl/eq_pkg.sv
// Shared constants for the CODEC I2S interface.
// Counter, sample and slot geometry used by codec_intf and i2s_shift.
package eq_pkg;

   localparam int CNT_W    = 11;
   localparam int SMP_W    = 16;
   localparam int SLOT_MSB = 1;
   localparam int SLOT_LSB = 16;

   localparam logic [CNT_W-1:0] FRAME_END = 11'h7FF;
   localparam logic [4:0]       RX_PHASE  = 5'h0F;
   localparam logic [4:0]       TX_PHASE  = 5'h1F;

   function automatic logic in_data(input logic [5:0] slot);
      return (slot >= 6'(SLOT_MSB)) && (slot <= 6'(SLOT_LSB));
   endfunction

endpackage

// File: rtl/codec_intf_i2s_shift.sv
// One channel of the I2S datapath: rx deserializer plus tx shadow word.
// The tx bit is selected by index so timing decode stays in the top.
module i2s_shift
   import eq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_en,
   input  logic             rx_bit,
   input  logic             load,
   input  logic [SMP_W-1:0] load_data,
   input  logic [3:0]       tx_idx,
   output logic [SMP_W-1:0] rx_data,
   output logic             tx_bit
);

   logic [SMP_W-1:0] shadow;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data <= '0;
         shadow  <= '0;
      end else begin
         if (rx_en)
            rx_data <= {rx_data[SMP_W-2:0], rx_bit};
         if (load)
            shadow <= load_data;
      end
   end

   assign tx_bit = shadow[tx_idx];

endmodule

// File: rtl/codec_intf.sv
// I2S CODEC interface: clock generation, frame timing, rx/tx per channel.
// Define CODEC_LOOPBACK_EN to reload the tx words from the rx words.
module codec_intf
   import eq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [SMP_W-1:0] lft_in,
   input  logic [SMP_W-1:0] rht_in,
   input  logic             SDout,
   output logic [SMP_W-1:0] lft_out,
   output logic [SMP_W-1:0] rht_out,
   output logic             valid,
   output logic             MCLK,
   output logic             SCLK,
   output logic             LRCLK,
   output logic             SDin,
   output logic             RSTn
);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       frames;
   logic [1:0]       frames_nxt;
   logic [5:0]       slot;
   logic [5:0]       nxt_slot;
   logic [3:0]       tx_idx;
   logic             chan;
   logic             rx_fire;
   logic             tx_fire;
   logic             frame_end;
   logic [SMP_W-1:0] rx_l;
   logic [SMP_W-1:0] rx_r;
   logic [SMP_W-1:0] ld_l;
   logic [SMP_W-1:0] ld_r;
   logic             tx_l;
   logic             tx_r;

   assign chan      = cnt[10];
   assign slot      = {1'b0, cnt[9:5]};
   assign nxt_slot  = slot + 6'd1;
   assign tx_idx    = 4'(6'(SLOT_LSB) - nxt_slot);
   assign rx_fire   = (cnt[4:0] == RX_PHASE) && in_data(slot);
   assign tx_fire   = (cnt[4:0] == TX_PHASE);
   assign frame_end = (cnt == FRAME_END);
   assign frames_nxt = (frames == 2'd3) ? 2'd3 : frames + 2'd1;

`ifdef CODEC_LOOPBACK_EN
   assign ld_l = rx_l;
   assign ld_r = rx_r;
`else
   assign ld_l = lft_in;
   assign ld_r = rht_in;
`endif

   i2s_shift u_lft (
      .clk(clk), .rst(rst),
      .rx_en(rx_fire && !chan), .rx_bit(SDout),
      .load(frame_end), .load_data(ld_l),
      .tx_idx(tx_idx), .rx_data(rx_l), .tx_bit(tx_l)
   );

   i2s_shift u_rht (
      .clk(clk), .rst(rst),
      .rx_en(rx_fire && chan), .rx_bit(SDout),
      .load(frame_end), .load_data(ld_r),
      .tx_idx(tx_idx), .rx_data(rx_r), .tx_bit(tx_r)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         frames  <= '0;
         lft_out <= '0;
         rht_out <= '0;
         valid   <= 1'b0;
         MCLK    <= 1'b0;
         SCLK    <= 1'b0;
         LRCLK   <= 1'b0;
         SDin    <= 1'b0;
         RSTn    <= 1'b0;
      end else begin
         cnt   <= cnt + CNT_W'(1);
         MCLK  <= cnt[1];
         SCLK  <= cnt[4];
         LRCLK <= cnt[10];
         valid <= 1'b0;
         if (tx_fire)
            SDin <= in_data(nxt_slot) ? (chan ? tx_r : tx_l) : 1'b0;
         if (frame_end) begin
            lft_out <= rx_l;
            rht_out <= rx_r;
            RSTn    <= 1'b1;
            // the frame that raises RSTn is not counted
            if (RSTn) begin
               frames <= frames_nxt;
               valid  <= frames_nxt[1];
            end
         end
      end
   end

endmodule

// File: tb/tb_codec_intf.sv
// Bench for codec_intf: random CODEC data and DAC words against a frame-level model.
// Build with CODEC_LOOPBACK_EN defined to exercise the loopback variant.
module tb_codec_intf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] lft_in = '0;
   logic [15:0] rht_in = '0;
   logic        SDout = 1'b0;
   logic [15:0] lft_out;
   logic [15:0] rht_out;
   logic        valid;
   logic        MCLK;
   logic        SCLK;
   logic        LRCLK;
   logic        SDin;
   logic        RSTn;

   codec_intf dut (
      .clk(clk), .rst(rst),
      .lft_in(lft_in), .rht_in(rht_in), .SDout(SDout),
      .lft_out(lft_out), .rht_out(rht_out), .valid(valid),
      .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK),
      .SDin(SDin), .RSTn(RSTn)
   );

   always #10 clk = ~clk;

`ifdef CODEC_LOOPBACK_EN
   localparam logic [15:0] CODEC_L = 16'h1234;
   localparam logic [15:0] EXP_TX_L = 16'h1234;
   localparam logic [15:0] EXP_TX_R = 16'h7FFE;
`else
   localparam logic [15:0] CODEC_L = 16'h8001;
   localparam logic [15:0] EXP_TX_L = 16'hA5A5;
   localparam logic [15:0] EXP_TX_R = 16'h5A5A;
`endif
   localparam logic [15:0] CODEC_R = 16'h7FFE;

   int n_chk = 0;
   int n_fail = 0;
   int k = 0;
   int valids = 0;
   logic [15:0] rx_l [8];
   logic [15:0] rx_r [8];
   logic [15:0] tx_l [8];
   logic [15:0] tx_r [8];
   logic [15:0] des_l;
   logic [15:0] des_r;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at k=%0d: actual %h required %h",
                     nm, k, act, exp);
      end
   endtask

   // bit carried in the slot containing frame position c (MSB in slot 1)
   function automatic logic sbit(input logic [15:0] w, input int c);
      int s;
      s = (c >> 5) & 31;
      if (s >= 1 && s <= 16)
         return w[16-s];
      return 1'b0;
   endfunction

   task automatic new_frames();
      for (int f = 0; f < 8; f++) begin
         rx_l[f] = 16'($urandom);
         rx_r[f] = 16'($urandom);
         tx_l[f] = '0;
         tx_r[f] = '0;
      end
      rx_l[2] = CODEC_L;
      rx_r[2] = CODEC_R;
   endtask

   task automatic check_reset();
      chk("rst_valid", 16'(valid), 16'h0);
      chk("rst_lft", lft_out, 16'h0);
      chk("rst_rht", rht_out, 16'h0);
      chk("rst_rstn", 16'(RSTn), 16'h0);
      chk("rst_sdin", 16'(SDin), 16'h0);
      chk("rst_mclk", 16'(MCLK), 16'h0);
      chk("rst_sclk", 16'(SCLK), 16'h0);
      chk("rst_lrclk", 16'(LRCLK), 16'h0);
   endtask

   // interval i = i-th clock period since the first post-release cycle (cnt==0)
   task automatic run(input int ncyc);
      int f, c, s, ch;
      logic [15:0] w;
      for (int i = 0; i < ncyc; i++) begin
         k  = i;
         f  = i / 2048;
         c  = i % 2048;
         s  = (c >> 5) & 31;
         ch = c >> 10;
         w  = ch ? rx_r[f] : rx_l[f];
         SDout = (s >= 1 && s <= 16) ? sbit(w, c) : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 63) == 0) lft_in = 16'($urandom);
         if ($urandom_range(0, 63) == 0) rht_in = 16'($urandom);
         if (f == 2 && c == 2047) begin
            lft_in = 16'hA5A5;
            rht_in = 16'h5A5A;
         end
         if (c == 2047) begin
`ifdef CODEC_LOOPBACK_EN
            tx_l[f] = rx_l[f];
            tx_r[f] = rx_r[f];
`else
            tx_l[f] = lft_in;
            tx_r[f] = rht_in;
`endif
         end
         chk("mclk", 16'(MCLK), i == 0 ? 16'h0 : 16'(((i - 1) >> 1) & 1));
         chk("sclk", 16'(SCLK), i == 0 ? 16'h0 : 16'(((i - 1) >> 4) & 1));
         chk("lrclk", 16'(LRCLK), i == 0 ? 16'h0 : 16'(((i - 1) >> 10) & 1));
         chk("rstn", 16'(RSTn), 16'(i >= 2048));
         chk("valid", 16'(valid), 16'(i >= 6144 && c == 0));
         chk("lft_out", lft_out, f >= 1 ? rx_l[f-1] : 16'h0);
         chk("rht_out", rht_out, f >= 1 ? rx_r[f-1] : 16'h0);
         w = (f >= 1) ? (ch ? tx_r[f-1] : tx_l[f-1]) : 16'h0;
         chk("sdin", 16'(SDin), 16'(sbit(w, c)));
         if (valid) valids++;
         if (i == 2047) chk("rstn_before_2048", 16'(RSTn), 16'h0);
         if (i == 2048) chk("rstn_at_2048", 16'(RSTn), 16'h1);
         if (i == 6143) chk("no_valid_6143", 16'(valid), 16'h0);
         if (i == 6144) begin
            chk("first_valid", 16'(valid), 16'h1);
            chk("first_valid_lft", lft_out, CODEC_L);
            chk("first_valid_rht", rht_out, CODEC_R);
         end
         if (i == 6145) chk("valid_width", 16'(valid), 16'h0);
         if (f == 3 && c == 0) begin
            des_l = '0;
            des_r = '0;
         end
         if (f == 3 && (c % 32) == 16 && s >= 1 && s <= 16) begin
            if (ch == 0) des_l = {des_l[14:0], SDin};
            else         des_r = {des_r[14:0], SDin};
         end
         if (f == 3 && c == 2047) begin
            chk("deser_l", des_l, EXP_TX_L);
            chk("deser_r", des_r, EXP_TX_R);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      new_frames();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset();
      rst = 1'b0;
      valids = 0;
      run(5 * 2048 + 1000);
      chk("valid_count_1", 16'(valids), 16'd3);
      rst = 1'b1;
      @(negedge clk);
      check_reset();
      repeat (2) @(negedge clk);
      check_reset();
      rst = 1'b0;
      new_frames();
      valids = 0;
      run(4 * 2048 + 8);
      chk("valid_count_2", 16'(valids), 16'd2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
